osd_dii_arbiter: RTL and testbench

OSD_DII_ARBITER -- requirements
Module: osd_dii_arbiter

---
 rtl/dii_package.sv | 11 +
 rtl/osd_rr_arbiter.sv | 30 +++
 rtl/osd_dii_arbiter.sv | 134 +++++++++++++
 tb/tb_osd_dii_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dii_package.sv
// Shared DII definitions: default flit width and the arbiter state encoding.
package dii_package;

    localparam int FLIT_W_DEFAULT = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Rotating-priority search: grants the first requester at or above ptr,
// wrapping modulo N. Purely combinational.
module osd_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int   j;
    logic found;

    // Walk the ports starting at ptr; the first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!found && req[j[PW-1:0]]) begin
                gnt[j[PW-1:0]] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_dii_arbiter.sv
// Packet-granular DII arbiter: merges N flit streams onto one output,
// holding ownership from a first flit until the matching last flit.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | no owner; search for a first flit, discard stray flits
// ST_LOCKED | owner streams flits until its last flit is accepted
module osd_dii_arbiter
    import dii_package::*;
#(
    parameter int N      = 2,
    parameter int FLIT_W = FLIT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0][FLIT_W-1:0] in_data,
    input  logic [N-1:0]             in_first,
    input  logic [N-1:0]             in_last,
    input  logic [N-1:0]             in_valid,
    output logic [N-1:0]             in_ready,
    input  logic [N-1:0]             en_mask,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_first,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             grant,
    output logic                     err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    arb_state_t    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] gnt_idx, sel_idx;
    logic [N-1:0]  first_req, junk_req, junk_sel;
    logic [N-1:0]  rr_gnt, owner_oh, sel_oh, ready_c;
    logic          can_take, accept, err_d;

    assign can_take  = !out_valid || out_ready;
    assign first_req = in_valid & in_first & en_mask;
    assign junk_req  = in_valid & ~in_first & en_mask;
    // Lowest-index stray flit is the one discarded this cycle.
    assign junk_sel  = junk_req & (~junk_req + {{(N-1){1'b0}}, 1'b1});

    osd_rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req (first_req),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // One-hot to index for the fresh grant, index to one-hot for the owner.
    always_comb begin
        gnt_idx  = '0;
        owner_oh = '0;
        for (int i = 0; i < N; i++) begin
            if (rr_gnt[i]) gnt_idx = PW'(i);
            owner_oh[i] = (owner_q == PW'(i));
        end
    end

    // Next-state, ready and error decode.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        sel_oh   = '0;
        sel_idx  = owner_q;
        ready_c  = '0;
        err_d    = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_oh  = rr_gnt;
                sel_idx = gnt_idx;
                ready_c = (rr_gnt & {N{can_take}}) | junk_sel;
                err_d   = |junk_sel;
                if (|rr_gnt) begin
                    owner_d = gnt_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                sel_oh  = owner_oh;
                sel_idx = owner_q;
                ready_c = owner_oh & {N{can_take}};
            end
            default: state_d = ST_IDLE;
        endcase
        accept = |(in_valid & ready_c & sel_oh);
        if (accept) begin
            if (state_q == ST_LOCKED && in_first[sel_idx]) err_d = 1'b1;
            // Single-flit packets drop straight back to IDLE so the next
            // grant is evaluated a cycle later with the advanced pointer.
            if (in_last[sel_idx]) begin
                state_d  = ST_IDLE;
                rr_ptr_d = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + PW'(1);
            end
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign in_ready = ready_c & {N{rst_n}};
    assign grant    = sel_oh & {N{rst_n}};

    // State, pointer, owner and the single output flit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            err      <= err_d;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[sel_idx];
                out_first <= in_first[sel_idx];
                out_last  <= in_last[sel_idx];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_osd_dii_arbiter.sv
// Directed bench for osd_dii_arbiter with four ports and 16-bit flits.
module tb_osd_dii_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]       in_first, in_last, in_valid, in_ready, en_mask, grant;
    logic [W-1:0]       out_data;
    logic               out_first, out_last, out_valid, out_ready, err;

    int           total = 0;
    int           bad = 0;
    int           flen[N], fidx[N], cnt[N];
    logic [3:0]   pk[N];
    logic [N-1:0] autold, nofirst, en_nxt;
    logic         ordy_nxt;
    logic [W-1:0] out_log[$];
    int           seq_ordy[4] = '{1, 0, 0, 1};
    int           seq_ir[4]   = '{1, 0, 0, 1};
    int           seq_f[4]    = '{0, 1, 1, 1};

    osd_dii_arbiter #(.N(N), .FLIT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en_mask   (en_mask),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] fl(input int p, input int k, input int f);
        return {4'hA, 4'(p), 4'(k), 4'(f)};
    endfunction

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        for (int p = 0; p < N; p++) begin
            in_valid[p] = (fidx[p] < flen[p]);
            in_first[p] = in_valid[p] && (fidx[p] == 0) && !nofirst[p];
            in_last[p]  = in_valid[p] && (fidx[p] == flen[p] - 1);
            in_data[p]  = nofirst[p] ? 16'hBEEF : fl(p, int'(pk[p]), fidx[p]);
        end
    endtask

    task automatic load(input int p, input int len, input int k);
        flen[p] = len;
        fidx[p] = 0;
        pk[p]   = 4'(k);
    endtask

    task automatic clear_src();
        for (int p = 0; p < N; p++) begin
            flen[p] = 0;
            fidx[p] = 0;
            cnt[p]  = 0;
            pk[p]   = 4'h0;
        end
        autold  = '0;
        nofirst = '0;
        out_log.delete();
    endtask

    // One clock: record handshakes, advance sources after the edge, land on negedge.
    task automatic tick();
        logic [N-1:0] hs;
        hs = in_valid & in_ready;
        if (out_valid && out_ready) out_log.push_back(out_data);
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (hs[p]) begin
                cnt[p]++;
                fidx[p]++;
                if (fidx[p] >= flen[p] && autold[p]) begin
                    fidx[p] = 0;
                    pk[p]   = pk[p] + 4'h1;
                end
            end
        end
        en_mask   = en_nxt;
        out_ready = ordy_nxt;
        apply_inputs();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        clear_src();
        apply_inputs();
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        clear_src();
        en_mask   = '1;
        en_nxt    = '1;
        out_ready = 1'b0;
        ordy_nxt  = 1'b0;
        apply_inputs();

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 0, 32'(out_valid), 32'h0);
        check("rst_out_data", 0, 32'(out_data), 32'h0);
        check("rst_out_fl", 0, 32'({out_first, out_last}), 32'h0);
        check("rst_grant", 0, 32'(grant), 32'h0);
        check("rst_in_ready", 0, 32'(in_ready), 32'h0);
        check("rst_err", 0, 32'(err), 32'h0);
        rst_n = 1'b1;

        // Two 3-flit packets, no interleaving
        load(0, 3, 1);
        load(1, 3, 1);
        out_ready = 1'b1;
        ordy_nxt  = 1'b1;
        apply_inputs();
        #1;
        check("pk_grant", 0, 32'(grant), 32'h1);
        check("pk_in_ready", 0, 32'(in_ready), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("pk_valid", k, 32'(out_valid), 32'h1);
            check("pk_data", k, 32'(out_data), 32'(k <= 3 ? fl(0, 1, k - 1) : fl(1, 1, k - 4)));
            check("pk_grant", k, 32'(grant), (k <= 2) ? 32'h1 : ((k <= 5) ? 32'h2 : 32'h0));
        end
        tick();
        check("pk_drain", 7, 32'(out_valid), 32'h0);
        check("pk_count", 7, 32'(out_log.size()), 32'd6);

        // Four ports with continuous 1-flit packets
        pulse_reset();
        for (int p = 0; p < N; p++) load(p, 1, 0);
        autold = '1;
        apply_inputs();
        #1;
        for (int c = 0; c < 40; c++) begin
            if (c < 5) check("rr_grant", c, 32'(grant), 32'(1 << (c % 4)));
            tick();
        end
        for (int p = 0; p < N; p++) check("rr_share", p, 32'(cnt[p]), 32'd10);
        check("rr_logged", 0, 32'(out_log.size()), 32'd39);
        check("rr_err", 0, 32'(err), 32'h0);
        autold = '0;
        for (int p = 0; p < N; p++) flen[p] = 0;
        apply_inputs();
        #1;
        tick();
        tick();

        // Backpressure mid-packet
        pulse_reset();
        load(2, 4, 3);
        apply_inputs();
        #1;
        check("bp_grant", 0, 32'(grant), 32'h4);
        for (int k = 1; k <= 4; k++) begin
            ordy_nxt = seq_ordy[k - 1][0];
            tick();
            check("bp_data", k, 32'(out_data), 32'(fl(2, 3, seq_f[k - 1])));
            check("bp_valid", k, 32'(out_valid), 32'h1);
            check("bp_in_ready", k, 32'(in_ready), seq_ir[k - 1] != 0 ? 32'h4 : 32'h0);
        end
        ordy_nxt = 1'b1;
        tick();
        tick();
        tick();
        check("bp_drain", 7, 32'(out_valid), 32'h0);
        check("bp_count", 0, 32'(out_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check("bp_log", i, 32'(out_log[i]), 32'(fl(2, 3, i)));

        // Stray non-first flit while idle
        nofirst[1] = 1'b1;
        flen[1]    = 1;
        fidx[1]    = 0;
        out_log.delete();
        apply_inputs();
        #1;
        check("junk_in_ready", 0, 32'(in_ready), 32'h2);
        check("junk_grant", 0, 32'(grant), 32'h0);
        check("junk_err_pre", 0, 32'(err), 32'h0);
        tick();
        check("junk_taken", 1, 32'(cnt[1]), 32'd1);
        check("junk_err", 1, 32'(err), 32'h1);
        check("junk_valid", 1, 32'(out_valid), 32'h0);
        tick();
        check("junk_err", 2, 32'(err), 32'h0);
        check("junk_valid", 2, 32'(out_valid), 32'h0);
        nofirst[1] = 1'b0;
        flen[1]    = 0;

        // Owner disabled mid-packet keeps its grant, then is skipped
        pulse_reset();
        load(0, 4, 5);
        load(1, 2, 5);
        autold[0] = 1'b1;
        apply_inputs();
        #1;
        check("en_grant", 0, 32'(grant), 32'h1);
        en_nxt = 4'b1110;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("en_grant", k, 32'(grant), 32'h1);
        end
        tick();
        check("en_grant", 4, 32'(grant), 32'h2);
        check("en_in_ready", 4, 32'(in_ready), 32'h2);
        tick();
        check("en_grant", 5, 32'(grant), 32'h2);
        tick();
        check("en_grant", 6, 32'(grant), 32'h0);
        check("en_in_ready", 6, 32'(in_ready), 32'h0);
        tick();
        check("en_count", 0, 32'(out_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < out_log.size(); i++)
            check("en_log", i, 32'(out_log[i]), 32'(i < 4 ? fl(0, 5, i) : fl(1, 5, i - 4)));
        autold[0] = 1'b0;
        flen[0]   = 0;
        en_nxt    = '1;

        // Reset mid-packet, then arbitration restarts from port 0
        load(2, 1, 7);
        load(1, 4, 7);
        en_mask = '1;
        apply_inputs();
        #1;
        check("mr_grant", 0, 32'(grant), 32'h4);
        tick();
        check("mr_grant", 1, 32'(grant), 32'h2);
        tick();
        tick();
        check("mr_data", 3, 32'(out_data), 32'(fl(1, 7, 1)));
        rst_n = 1'b0;
        #1;
        check("mr_valid", 0, 32'(out_valid), 32'h0);
        check("mr_out_data", 0, 32'(out_data), 32'h0);
        check("mr_grant_rst", 0, 32'(grant), 32'h0);
        check("mr_in_ready", 0, 32'(in_ready), 32'h0);
        clear_src();
        apply_inputs();
        #1;
        rst_n = 1'b1;
        load(2, 1, 8);
        load(3, 1, 8);
        apply_inputs();
        #1;
        check("mr_regrant", 0, 32'(grant), 32'h4);
        tick();
        check("mr_data2", 1, 32'(out_data), 32'(fl(2, 8, 0)));
        check("mr_regrant", 1, 32'(grant), 32'h8);
        tick();
        check("mr_data3", 2, 32'(out_data), 32'(fl(3, 8, 0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
